fpu_mul_arbiter: RTL and testbench

Round-robin controller that shares one `fpu_sp_multiplier` instance among `NREQ` requesters over valid/ready handshakes. It registers the granted operands, runs the multiplier for one cycle, then holds the tagged result until the consumer accepts it. It sits between the issue logic of several FPU clients and the single-precision multiply datapath.

---
 rtl/fpu_pkg.sv | 20 ++
 rtl/fpu_rr_arbiter.sv | 35 +++
 rtl/fpu_sp_multiplier.sv | 58 +++++
 rtl/fpu_mul_arbiter.sv | 126 ++++++++++++
 tb/tb_fpu_mul_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpu_pkg
// Brief    : Shared constants and types for the shared FPU unit wrappers.
// Revision : 1.0 - initial release
// ============================================================================
package fpu_pkg;

  localparam int FP_WIDTH = 32;
  localparam int FP_EXP_W = 8;
  localparam int FP_BIAS  = 127;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/fpu_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fpu_rr_arbiter
// Brief    : Combinational round-robin pick, searching upward from last+1.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [NREQ-1:0] grant_onehot,
  output logic [IDW-1:0]  grant_id
);

  logic [IDW-1:0] w_idx;

  // Walk the search order backwards so the nearest requester after 'last' wins.
  always_comb begin
    grant_onehot = '0;
    grant_id     = '0;
    w_idx        = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = IDW'((int'(last) + k) % NREQ);
      if (req[w_idx]) begin
        grant_onehot        = '0;
        grant_onehot[w_idx] = 1'b1;
        grant_id            = w_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fpu_sp_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : fpu_sp_multiplier
// Brief    : Combinational IEEE-754 multiply; truncating, flush-to-zero, no NaN.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_sp_multiplier import fpu_pkg::*; #(
  parameter int WIDTH = FP_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_overflow,
  output logic             o_underflow
);

  localparam int MAN_W   = WIDTH - 1 - FP_EXP_W;
  localparam int PROD_W  = 2 * (MAN_W + 1);
  localparam int EXP_MAX = (1 << FP_EXP_W) - 1;

  logic                w_sign;
  logic [FP_EXP_W-1:0] w_exp_a;
  logic [FP_EXP_W-1:0] w_exp_b;
  logic [PROD_W-1:0]   w_prod;
  logic                w_norm;
  logic [MAN_W-1:0]    w_man;
  logic                w_unused_lsbs;
  int                  w_exp_i;

  assign w_sign  = i_a[WIDTH-1] ^ i_b[WIDTH-1];
  assign w_exp_a = i_a[WIDTH-2 -: FP_EXP_W];
  assign w_exp_b = i_b[WIDTH-2 -: FP_EXP_W];
  assign w_prod  = PROD_W'({1'b1, i_a[MAN_W-1:0]}) * PROD_W'({1'b1, i_b[MAN_W-1:0]});
  assign w_norm  = w_prod[PROD_W-1];
  assign w_man   = w_norm ? w_prod[PROD_W-2 -: MAN_W] : w_prod[PROD_W-3 -: MAN_W];
  assign w_unused_lsbs = ^w_prod[MAN_W-1:0];

  // Zero/denormal inputs flush to signed zero; inf/NaN inputs give signed infinity.
  always_comb begin
    w_exp_i     = int'(w_exp_a) + int'(w_exp_b) - FP_BIAS + int'(w_norm);
    o_result    = {w_sign, w_exp_i[FP_EXP_W-1:0], w_man};
    o_overflow  = 1'b0;
    o_underflow = 1'b0;
    if (w_exp_a == '0 || w_exp_b == '0) begin
      o_result = {w_sign, {(WIDTH-1){1'b0}}};
    end else if (w_exp_a == FP_EXP_W'(EXP_MAX) || w_exp_b == FP_EXP_W'(EXP_MAX)) begin
      o_result = {w_sign, {FP_EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_exp_i >= EXP_MAX) begin
      o_result   = {w_sign, {FP_EXP_W{1'b1}}, {MAN_W{1'b0}}};
      o_overflow = 1'b1;
    end else if (w_exp_i <= 0) begin
      o_result    = {w_sign, {(WIDTH-1){1'b0}}};
      o_underflow = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fpu_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fpu_mul_arbiter
// Brief    : Round-robin sharing of one single-precision multiplier among NREQ.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_mul_arbiter import fpu_pkg::*; #(
  parameter  int WIDTH = FP_WIDTH,
  parameter  int NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_result,
  output logic                  rsp_overflow,
  output logic                  rsp_underflow,
  output logic                  busy
);

  arb_state_t       r_state_q, w_state_d;
  logic [IDW-1:0]   r_last_q, w_last_d;
  logic [IDW-1:0]   r_id_q, w_id_d;
  logic [WIDTH-1:0] r_a_q, w_a_d;
  logic [WIDTH-1:0] r_b_q, w_b_d;
  logic [WIDTH-1:0] r_res_q, w_res_d;
  logic             r_ovf_q, w_ovf_d;
  logic             r_unf_q, w_unf_d;
  logic [NREQ-1:0]  w_grant_onehot;
  logic [IDW-1:0]   w_grant_id;
  logic [WIDTH-1:0] w_mul_res;
  logic             w_mul_ovf;
  logic             w_mul_unf;
  logic             w_any_req;

  assign w_any_req = |req_valid;

  fpu_rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req          (req_valid),
    .last         (r_last_q),
    .grant_onehot (w_grant_onehot),
    .grant_id     (w_grant_id)
  );

  fpu_sp_multiplier #(.WIDTH(WIDTH)) u_mul (
    .i_a         (r_a_q),
    .i_b         (r_b_q),
    .o_result    (w_mul_res),
    .o_overflow  (w_mul_ovf),
    .o_underflow (w_mul_unf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= IDLE;
      r_last_q  <= IDW'(NREQ - 1);
      r_id_q    <= '0;
      r_a_q     <= '0;
      r_b_q     <= '0;
      r_res_q   <= '0;
      r_ovf_q   <= 1'b0;
      r_unf_q   <= 1'b0;
    end else begin
      r_state_q <= w_state_d;
      r_last_q  <= w_last_d;
      r_id_q    <= w_id_d;
      r_a_q     <= w_a_d;
      r_b_q     <= w_b_d;
      r_res_q   <= w_res_d;
      r_ovf_q   <= w_ovf_d;
      r_unf_q   <= w_unf_d;
    end
  end

  always_comb begin
    w_state_d = r_state_q;
    case (r_state_q)
      IDLE:    if (w_any_req) w_state_d = EXEC;
      EXEC:    w_state_d = RESP;
      RESP:    if (rsp_ready) w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_comb begin
    w_last_d = r_last_q;
    w_id_d   = r_id_q;
    w_a_d    = r_a_q;
    w_b_d    = r_b_q;
    w_res_d  = r_res_q;
    w_ovf_d  = r_ovf_q;
    w_unf_d  = r_unf_q;
    if (r_state_q == IDLE && w_any_req) begin
      w_last_d = w_grant_id;
      w_id_d   = w_grant_id;
      w_a_d    = req_a[int'(w_grant_id)*WIDTH +: WIDTH];
      w_b_d    = req_b[int'(w_grant_id)*WIDTH +: WIDTH];
    end
    if (r_state_q == EXEC) begin
      w_res_d = w_mul_res;
      w_ovf_d = w_mul_ovf;
      w_unf_d = w_mul_unf;
    end
  end

  // Ready is held low during reset so a requester never sees a dropped accept.
  always_comb begin
    req_ready = '0;
    if (r_state_q == IDLE && !rst) req_ready = w_grant_onehot;
    rsp_valid = (r_state_q == RESP);
    busy      = (r_state_q != IDLE);
  end

  assign rsp_id        = r_id_q;
  assign rsp_result    = r_res_q;
  assign rsp_overflow  = r_ovf_q;
  assign rsp_underflow = r_unf_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_mul_arbiter
// Brief    : Scoreboard bench for the shared multiplier arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_mul_arbiter;

  localparam int S_IDLE = 0;
  localparam int S_EXEC = 1;
  localparam int S_RESP = 2;

  typedef struct {
    int          id;
    logic [31:0] res;
    logic        ovf;
    logic        unf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_result;
  logic         rsp_overflow;
  logic         rsp_underflow;
  logic         busy;

  exp_t        sb_q[$];
  int          grant_log[$];
  int          grant_cyc[$];
  int          rsp_cyc[$];
  int          rsp_ids[$];
  logic [31:0] exp_res[4];
  logic        exp_ovf[4];
  logic        exp_unf[4];
  int          m_state, m_next, m_last, m_last_n, cyc;
  int          n_cmp, n_bad;
  logic [31:0] last_res;
  logic        last_ovf, last_unf;

  fpu_mul_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_result    (rsp_result),
    .rsp_overflow  (rsp_overflow),
    .rsp_underflow (rsp_underflow),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  function automatic int rr_pick(input logic [3:0] v, input int last);
    int idx;
    for (int k = 1; k <= 4; k++) begin
      idx = (last + k) % 4;
      if (v[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input logic o, input logic u);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    exp_res[i] = r;
    exp_ovf[i] = o;
    exp_unf[i] = u;
  endtask

  // Scoreboard: predict handshakes from a cycle model, push on accept, pop on response.
  task automatic sample();
    int         g;
    logic [3:0] exp_rdy;
    exp_t       e;
    @(negedge clk);
    g = (m_state == S_IDLE && !rst) ? rr_pick(req_valid, m_last) : -1;
    exp_rdy = 4'b0;
    if (g >= 0) exp_rdy[g[1:0]] = 1'b1;
    n_cmp++;
    if (req_ready !== exp_rdy) begin
      n_bad++;
      $display("FAIL req_ready cyc=%0d: got %b expected %b", cyc, req_ready, exp_rdy);
    end
    n_cmp++;
    if (busy !== (m_state != S_IDLE)) begin
      n_bad++;
      $display("FAIL busy cyc=%0d: got %b expected %0d", cyc, busy, m_state != S_IDLE);
    end
    n_cmp++;
    if (rsp_valid !== (m_state == S_RESP)) begin
      n_bad++;
      $display("FAIL rsp_valid cyc=%0d: got %b expected %0d", cyc, rsp_valid, m_state == S_RESP);
    end
    if (m_state == S_RESP) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard cyc=%0d: response with nothing expected", cyc);
      end else begin
        e = sb_q[0];
        if (rsp_id !== 2'(e.id) || rsp_result !== e.res ||
            rsp_overflow !== e.ovf || rsp_underflow !== e.unf) begin
          n_bad++;
          $display("FAIL payload cyc=%0d: got id=%0d res=%h ovf=%b unf=%b expected id=%0d res=%h ovf=%b unf=%b",
                   cyc, rsp_id, rsp_result, rsp_overflow, rsp_underflow, e.id, e.res, e.ovf, e.unf);
        end
        if (rsp_ready) begin
          e = sb_q.pop_front();
          rsp_cyc.push_back(cyc);
          rsp_ids.push_back(int'(rsp_id));
          last_res = rsp_result;
          last_ovf = rsp_overflow;
          last_unf = rsp_underflow;
        end
      end
    end
    m_next   = m_state;
    m_last_n = m_last;
    if (rst) begin
      m_next   = S_IDLE;
      m_last_n = 3;
      sb_q.delete();
    end else begin
      case (m_state)
        S_IDLE: if (g >= 0) begin
          m_next   = S_EXEC;
          m_last_n = g;
          sb_q.push_back(exp_t'{id: g, res: exp_res[g], ovf: exp_ovf[g], unf: exp_unf[g]});
          grant_log.push_back(g);
          grant_cyc.push_back(cyc);
        end
        S_EXEC:  m_next = S_RESP;
        default: if (rsp_ready) m_next = S_IDLE;
      endcase
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    m_state = m_next;
    m_last  = m_last_n;
    cyc++;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb_q.size());
      sb_q.delete();
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'b0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0;
    tick();
    tick();
    rst = 1'b0;
    sample();
    n_cmp++;
    if (rsp_id !== 2'd0 || rsp_result !== 32'h0 || rsp_overflow !== 1'b0 ||
        rsp_underflow !== 1'b0 || req_ready !== 4'b0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_values: got id=%0d res=%h ovf=%b unf=%b rdy=%b vld=%b busy=%b expected all 0",
               rsp_id, rsp_result, rsp_overflow, rsp_underflow, req_ready, rsp_valid, busy);
    end
    advance();
  endtask

  task automatic test_single();
    set_op(2, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b0);
    rsp_ready = 1'b1; req_valid = 4'b0100;
    sample();
    n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_bad++; $display("FAIL single_ready: got %b expected 0100", req_ready);
    end
    advance();
    req_valid = 4'b0;
    sample();
    n_cmp++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL single_exec: got vld=%b busy=%b expected vld=0 busy=1", rsp_valid, busy);
    end
    advance();
    sample();
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_result !== 32'h40C00000 ||
        rsp_overflow !== 1'b0 || rsp_underflow !== 1'b0) begin
      n_bad++;
      $display("FAIL single_rsp: got vld=%b id=%0d res=%h ovf=%b unf=%b expected 1 2 40c00000 0 0",
               rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_underflow);
    end
    advance();
    tick();
  endtask

  task automatic test_flags(input int id, input logic [31:0] op, input logic [31:0] r,
                            input logic o, input logic u);
    set_op(id, op, op, r, o, u);
    last_res = 32'hDEADBEEF; last_ovf = 1'bx; last_unf = 1'bx;
    req_valid = 4'b0;
    req_valid[id] = 1'b1;
    tick();
    req_valid = 4'b0;
    drain();
    n_cmp++;
    if (last_res !== r || last_ovf !== o || last_unf !== u) begin
      n_bad++;
      $display("FAIL flags_req%0d: got res=%h ovf=%b unf=%b expected res=%h ovf=%b unf=%b",
               id, last_res, last_ovf, last_unf, r, o, u);
    end
  endtask

  task automatic test_fairness();
    rst = 1'b1; tick(); rst = 1'b0;
    set_op(0, 32'h40000000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0);
    set_op(1, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b0);
    set_op(2, 32'h40000000, 32'h3F000000, 32'h3F800000, 1'b0, 1'b0);
    set_op(3, 32'h40000000, 32'h40800000, 32'h41000000, 1'b0, 1'b0);
    grant_log.delete(); grant_cyc.delete(); rsp_cyc.delete(); rsp_ids.delete();
    rsp_ready = 1'b1; req_valid = 4'b1111;
    repeat (15) tick();
    req_valid = 4'b0;
    drain();
    n_cmp++;
    if (grant_log.size() < 5 || rsp_ids.size() < 5) begin
      n_bad++;
      $display("FAIL fair_count: got %0d grants %0d responses expected >=5", grant_log.size(), rsp_ids.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (grant_log[i] != i % 4 || rsp_ids[i] != i % 4) begin
          n_bad++;
          $display("FAIL fair_order[%0d]: got grant=%0d rsp_id=%0d expected %0d", i, grant_log[i], rsp_ids[i], i % 4);
        end
      end
      for (int i = 1; i < 5; i++) begin
        n_cmp++;
        if (grant_cyc[i] - grant_cyc[i-1] != 3 || rsp_cyc[i] - rsp_cyc[i-1] != 3) begin
          n_bad++;
          $display("FAIL fair_spacing[%0d]: got grant gap=%0d rsp gap=%0d expected 3", i,
                   grant_cyc[i] - grant_cyc[i-1], rsp_cyc[i] - rsp_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    int held;
    rsp_ready = 1'b0; req_valid = 4'b1111;
    while (m_state != S_RESP && n < 10) begin
      tick();
      n++;
    end
    n_cmp++;
    if (m_state != S_RESP) begin
      n_bad++; $display("FAIL bp_wait: no response within 10 cycles, expected one");
    end
    held = m_last;
    repeat (5) begin
      sample();
      n_cmp++;
      if (req_ready !== 4'b0 || rsp_valid !== 1'b1 || rsp_id !== 2'(held) || rsp_result !== exp_res[held]) begin
        n_bad++;
        $display("FAIL bp_hold: got rdy=%b vld=%b id=%0d res=%h expected 0000 1 %0d %h",
                 req_ready, rsp_valid, rsp_id, rsp_result, held, exp_res[held]);
      end
      advance();
    end
    rsp_ready = 1'b1;
    tick();
    sample();
    n_cmp++;
    if (req_ready !== 4'(1 << ((held + 1) % 4))) begin
      n_bad++;
      $display("FAIL bp_next_grant: got %b expected %b", req_ready, 4'(1 << ((held + 1) % 4)));
    end
    advance();
    req_valid = 4'b0;
    drain();
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b1; req_valid = 4'b0100;
    tick();
    req_valid = 4'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    sample();
    n_cmp++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_idle: got busy=%b vld=%b expected 0 0", busy, rsp_valid);
    end
    advance();
    rsp_ids.delete();
    req_valid = 4'b1111;
    sample();
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_bad++; $display("FAIL rst_mid_grant: got %b expected 0001", req_ready);
    end
    advance();
    req_valid = 4'b0;
    repeat (6) tick();
    n_cmp++;
    if (rsp_ids.size() != 1) begin
      n_bad++; $display("FAIL rst_mid_count: got %0d responses expected 1", rsp_ids.size());
    end else begin
      n_cmp++;
      if (rsp_ids[0] != 0) begin
        n_bad++; $display("FAIL rst_mid_id: got %0d expected 0", rsp_ids[0]);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    m_state = S_IDLE; m_next = S_IDLE; m_last = 3; m_last_n = 3;
    for (int i = 0; i < 4; i++) begin
      exp_res[i] = '0; exp_ovf[i] = 1'b0; exp_unf[i] = 1'b0;
    end
    test_reset();
    test_single();
    test_flags(1, 32'h7F400000, 32'h7F800000, 1'b1, 1'b0);
    test_flags(3, 32'h00C00000, 32'h00000000, 1'b0, 1'b1);
    test_fairness();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
